// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Non-memory ops pass through
// combinationally. Aligned loads/stores run a registered request/acknowledge
// transaction on the data bus, with a bounded wait for dbus_ack.
module mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        is_load;
  logic        is_store;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        is_signed;
  logic        misaligned;
  logic        mem_go;
  logic [3:0]  sel_next;
  logic [31:0] wdata_next;
  logic        timeout_hit;

  logic [7:0]  cnt;
  logic [31:0] data_q;
  logic        wb_en_q;
  logic        load_q;
  logic        signed_q;
  logic [31:0] load_ext;

  // Decode the operation code into access kind, size and signedness.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    case (aluop_i)
      OP_LB:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      OP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign misaligned  = (is_half && mem_addr_i[0]) ||
                       (is_word && (mem_addr_i[1:0] != 2'b00));
  assign mem_go      = (is_load || is_store) && !misaligned;
  assign timeout_hit = (cnt == LAST_WAIT);

  // Big-endian lane select and replicated store data for the pending access.
  always_comb begin
    sel_next   = 4'b1111;
    wdata_next = reg2_i;
    if (is_byte) begin
      wdata_next = {4{reg2_i[7:0]}};
      case (mem_addr_i[1:0])
        2'b00:   sel_next = 4'b1000;
        2'b01:   sel_next = 4'b0100;
        2'b10:   sel_next = 4'b0010;
        default: sel_next = 4'b0001;
      endcase
    end else if (is_half) begin
      wdata_next = {2{reg2_i[15:0]}};
      sel_next   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end
  end

  // Extract the selected lane of the read data using the registered lanes.
  always_comb begin
    load_ext = dbus_rdata;
    case (dbus_sel)
      4'b1000: load_ext = {{24{signed_q & dbus_rdata[31]}}, dbus_rdata[31:24]};
      4'b0100: load_ext = {{24{signed_q & dbus_rdata[23]}}, dbus_rdata[23:16]};
      4'b0010: load_ext = {{24{signed_q & dbus_rdata[15]}}, dbus_rdata[15:8]};
      4'b0001: load_ext = {{24{signed_q & dbus_rdata[7]}},  dbus_rdata[7:0]};
      4'b1100: load_ext = {{16{signed_q & dbus_rdata[31]}}, dbus_rdata[31:16]};
      4'b0011: load_ext = {{16{signed_q & dbus_rdata[15]}}, dbus_rdata[15:0]};
      default: load_ext = dbus_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; an ack outside REQ has no effect.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_go) state_next = REQ;
      REQ:     if (dbus_ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus registers, wait counter and captured write-back data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= '0;
      dbus_wdata <= '0;
      bus_err_o  <= 1'b0;
      cnt        <= '0;
      data_q     <= '0;
      wb_en_q    <= 1'b0;
      load_q     <= 1'b0;
      signed_q   <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_go) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_addr  <= {mem_addr_i[31:2], 2'b00};
            dbus_sel   <= sel_next;
            dbus_wdata <= wdata_next;
            cnt        <= '0;
            load_q     <= is_load;
            signed_q   <= is_signed;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          // An ack on the last allowed cycle still completes the access.
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            data_q   <= load_q ? load_ext : '0;
            wb_en_q  <= load_q;
          end else if (timeout_hit) begin
            dbus_req  <= 1'b0;
            bus_err_o <= 1'b1;
            data_q    <= '0;
            wb_en_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Write-back triple, stall request and misalignment flag.
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq   = 1'b0;
    misalign_o = 1'b0;
    case (state)
      IDLE: begin
        if ((is_load || is_store) && misaligned) begin
          misalign_o = 1'b1;
          wreg_o     = 1'b0;
          wdata_o    = '0;
        end else if (mem_go) begin
          stallreq = 1'b1;
          wd_o     = '0;
          wreg_o   = 1'b0;
          wdata_o  = '0;
        end
      end
      REQ: begin
        stallreq = 1'b1;
        wd_o     = '0;
        wreg_o   = 1'b0;
        wdata_o  = '0;
      end
      DONE: begin
        wreg_o  = wreg_i && wb_en_q;
        wdata_o = data_q;
      end
      default: ;
    endcase
    if (rst) stallreq = 1'b0;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized and directed checks of mem_lsu against a
// transaction-level reference model, with the bench acting as bus slave.
module tb_mem_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        misalign_o;
  logic        bus_err_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Access size in bytes, 0 for non-memory ops.
  function automatic int unsigned op_size(input logic [7:0] op);
    case (op)
      8'hE0, 8'hE4, 8'hE8: return 1;
      8'hE1, 8'hE5, 8'hE9: return 2;
      8'hE3, 8'hEB:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [7:0] op);
    return (op == 8'hE0) || (op == 8'hE1) || (op == 8'hE3) ||
           (op == 8'hE4) || (op == 8'hE5);
  endfunction

  function automatic bit op_signed(input logic [7:0] op);
    return (op == 8'hE0) || (op == 8'hE1);
  endfunction

  // Apply one instruction (caller is just after a rising edge) and follow it
  // through to completion; wait_n = REQ cycles before the bench acks.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd,
                        input logic wreg, input logic [31:0] wdata,
                        input int unsigned wait_n, input logic [31:0] rdata);
    int unsigned sz;
    bit          ld;
    bit          mis;
    bit          acked;
    bit          done;
    logic [31:0] e_res;
    logic [31:0] e_wd;
    logic [3:0]  e_sel;
    logic [1:0]  b;
    int unsigned stall_cnt;
    int unsigned req_cnt;
    sz  = op_size(op);
    ld  = op_load(op);
    b   = addr[1:0];
    mis = (sz == 2 && addr[0]) || (sz == 4 && b != 2'b00);
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata; dbus_ack = 1'b0;

    if (sz == 0 || mis) begin
      @(negedge clk);
      check("pass_wd", wd_o, wd);
      check("pass_wreg", wreg_o, mis ? 1'b0 : wreg);
      check("pass_wdata", wdata_o, mis ? 32'h0 : wdata);
      check("pass_stall", stallreq, 0);
      check("pass_req", dbus_req, 0);
      check("misalign", misalign_o, mis);
      @(posedge clk); #1;
      return;
    end

    e_res = 32'h0;
    if (sz == 1) begin
      e_sel = 4'b1000 >> b;
      e_wd  = {4{reg2[7:0]}};
      e_res = (rdata >> (8 * (3 - b))) & 32'hFF;
      if (op_signed(op) && e_res[7]) e_res = e_res | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      e_sel = addr[1] ? 4'b0011 : 4'b1100;
      e_wd  = {2{reg2[15:0]}};
      e_res = (rdata >> (addr[1] ? 0 : 16)) & 32'hFFFF;
      if (op_signed(op) && e_res[15]) e_res = e_res | 32'hFFFF_0000;
    end else begin
      e_sel = 4'b1111;
      e_wd  = reg2;
      e_res = rdata;
    end
    acked = (wait_n < TO);
    if (!ld || !acked) e_res = 32'h0;

    stall_cnt = 0; req_cnt = 0; done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (!stallreq) begin
        done = 1;
        break;
      end
      stall_cnt++;
      if (stall_cnt == 1) begin
        check("issue_wreg", wreg_o, 0);
        check("issue_wdata", wdata_o, 0);
        check("issue_req", dbus_req, 0);
      end
      if (dbus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check("bus_addr", dbus_addr, {addr[31:2], 2'b00});
          check("bus_sel", dbus_sel, e_sel);
          check("bus_we", dbus_we, !ld);
          if (!ld) check("bus_wdata", dbus_wdata, e_wd);
        end
        if (req_cnt - 1 == wait_n) begin
          dbus_ack = 1'b1;
          dbus_rdata = rdata;
        end
      end
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      dbus_rdata = $urandom;
    end

    check("done_seen", done, 1);
    check("stall_cycles", stall_cnt, 1 + (acked ? wait_n + 1 : TO));
    check("req_cycles", req_cnt, acked ? wait_n + 1 : TO);
    check("done_wd", wd_o, wd);
    check("done_wreg", wreg_o, (ld && acked) ? wreg : 1'b0);
    check("done_wdata", wdata_o, e_res);
    check("done_err", bus_err_o, !acked);
    check("done_req", dbus_req, 0);

    // Idle cycle after DONE: error pulse gone, stray ack ignored.
    @(posedge clk); #1;
    aluop_i = 8'h00;
    dbus_ack = 1'($urandom);
    @(negedge clk);
    check("idle_err", bus_err_o, 0);
    check("idle_stall", stallreq, 0);
    check("idle_req", dbus_req, 0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
  endtask

  logic [7:0] mem_ops [8] = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB};

  initial begin
    logic [7:0] op;
    rst = 1'b1;
    aluop_i = 8'h00; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    mem_addr_i = '0; reg2_i = '0; dbus_ack = 1'b0; dbus_rdata = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_stall", stallreq, 0);
    check("rst_req", dbus_req, 0);
    check("rst_we", dbus_we, 0);
    check("rst_addr", dbus_addr, 0);
    check("rst_sel", dbus_sel, 0);
    check("rst_wdata", dbus_wdata, 0);
    check("rst_err", bus_err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases.
    run_op(8'h25, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 0, 32'h0);
    run_op(8'hE0, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0, 0, 32'h1122_33F0);
    run_op(8'hE5, 32'h202, 32'h0, 5'd9, 1'b1, 32'h0, 3, 32'hAAAA_8001);
    run_op(8'hE9, 32'h10, 32'hDEAD_BEEF, 5'd2, 1'b1, 32'h0, 1, 32'h0);
    run_op(8'hE3, 32'h6, 32'h0, 5'd4, 1'b1, 32'h55, 0, 32'h0);
    run_op(8'hE3, 32'h40, 32'h0, 5'd5, 1'b1, 32'h0, 99, 32'hCAFE_F00D);
    run_op(8'hE8, 32'h7F, 32'h0000_00A5, 5'd6, 1'b1, 32'h0, 2, 32'h0);
    run_op(8'hE1, 32'h302, 32'h0, 5'd8, 1'b1, 32'h0, 0, 32'h1234_8765);

    // Reset asserted while the access is in REQ.
    aluop_i = 8'hE3; mem_addr_i = 32'h80; wd_i = 5'd1; wreg_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_req_before", dbus_req, 1);
    rst = 1'b1;
    aluop_i = 8'h00;
    @(negedge clk);
    check("mid_rst_req", dbus_req, 0);
    check("mid_rst_stall", stallreq, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 7) op = mem_ops[$urandom_range(0, 7)];
      else                          op = 8'($urandom);
      run_op(op, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
             $urandom_range(0, 5), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
